multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sits directly upstream of the ALU control block: decodes the IR opcode, sequences the fetch/decode/execute/memory/writeback steps, and drives ALUOp into the ALU control block.
- Consumes jrEnable back from the ALU control block to redirect the PC on jr.
- Handshakes with a variable-latency memory through memReady.
- Counts retired instructions.

Parameters:
COUNT_WIDTH, 32, width of the retired-instruction counter instrCount.

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
opcode  input  6  IR[31:26] of the current instruction
jrEnable  input  1  from ALU control; 1 when funct=001000 under ALUOp=10
memReady  input  1  memory access completes this cycle
PCWrite  output  1  unconditional PC write
PCWriteCond  output  1  PC write if branch condition holds
branchNe  output  1  invert zero for the condition (bne)
IorD  output  1  0=PC address, 1=ALUOut address
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  latch instruction register
MemtoReg  output  1  1=MDR to register file, 0=ALUOut
RegDst  output  1  1=rd, 0=rt
RegWrite  output  1  register file write
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
ALUOp  output  2  00=add, 01=sub, 10=funct-decoded
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target, 11=register A (jr)
illegalOp  output  1  unsupported opcode seen in DECODE
state  output  4  current state encoding (debug)
instrCount  output  COUNT_WIDTH  retired instruction count

Behaviour:
- State encodings (4-bit state register):
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - RTYPEEX=6, RTYPEWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
  - Codes 12-15 unreachable; if entered, next state is FETCH with all outputs 0.
- Reset:
  - reset=1 at a clock edge: state<=FETCH, instrCount<=0.
  - While reset=1, every output is forced to 0 regardless of state, including mid-instruction.
- Outputs are a combinational decode of state (plus opcode/memReady/jrEnable where noted). Unlisted outputs are 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - memReady=1: IRWrite=1, PCWrite=1, next DECODE.
  - Else IRWrite=PCWrite=0; stay in FETCH.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - Next state by opcode: 000000->RTYPEEX; 100011 (lw) / 101011 (sw)->MEMADR; 000100 (beq) / 000101 (bne)->BRANCH; 001000 (addi)->ADDIEX; 000010 (j)->JUMP.
  - Any other opcode: illegalOp=1 this cycle, next FETCH, not counted.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; lw->MEMRD, sw->MEMWR.
- MEMRD: MemRead=1, IorD=1; hold until memReady, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next FETCH.
- MEMWR: MemWrite=1, IorD=1; hold until memReady, then FETCH. MemWrite stays asserted every cycle of the hold.
- RTYPEEX:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - jrEnable=1: PCWrite=1, PCSource=11, next FETCH, no register writeback.
  - Else next RTYPEWB.
- RTYPEWB: ALUOp=10 held, RegWrite=1, RegDst=1, MemtoReg=0; next FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - branchNe=1 iff opcode=000101.
  - Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; next FETCH.
- JUMP: PCWrite=1, PCSource=10; next FETCH.
- Retirement:
  - instrCount increments by 1 on each edge leaving a terminal state for FETCH: MEMWB, MEMWR (with memReady), RTYPEEX (jr), RTYPEWB, BRANCH, ADDIWB, JUMP.
  - Wraps modulo 2^COUNT_WIDTH.
  - Illegal-opcode exits are not counted.
- Latencies with memReady=1 throughout:
  - lw=5 cycles; sw, R-type, addi=4; beq/bne, j, jr=3.
  - Each memReady=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- opcode is read only in DECODE, MEMADR and BRANCH; the IR is stable there.

Test Plan:
- reset 2 cycles, memReady=1, opcode=100011 (lw) -> state 0,1,2,3,4,0; MemRead=1 in FETCH and MEMRD; RegWrite=1/MemtoReg=1 in MEMWB only; instrCount 0->1.
- sw with memReady low 3 cycles in MEMWR -> MemWrite=1 for 4 consecutive cycles, IorD=1; state 5 held; count increments once on exit.
- opcode=000000, jrEnable=1 in RTYPEEX -> PCWrite=1, PCSource=11, ALUOp=10, no RTYPEWB, RegWrite never 1; next state 0.
- opcode=000101 -> BRANCH with PCWriteCond=1, branchNe=1, ALUOp=01, PCSource=01; opcode=000100 gives branchNe=0.
- opcode=111111 -> illegalOp=1 in DECODE for exactly one cycle, next FETCH, instrCount unchanged.
- reset asserted during MEMRD -> all outputs 0 same cycle; next cycle state=0, instrCount=0. Also: 2^COUNT_WIDTH-1 retirements (COUNT_WIDTH=4, 15 j instructions) then one more -> instrCount wraps to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multicycle MIPS datapath
module multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             opcode,
  input  logic                   jrEnable,
  input  logic                   memReady,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   branchNe,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   MemtoReg,
  output logic                   RegDst,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             ALUOp,
  output logic [1:0]             PCSource,
  output logic                   illegalOp,
  output logic [3:0]             state,
  output logic [COUNT_WIDTH-1:0] instrCount
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  state_t cur, nxt;
  logic   retire;

  assign state = cur;

  always_comb begin
    nxt         = FETCH;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    branchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    illegalOp   = 1'b0;
    case (cur)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (memReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          nxt     = DECODE;
        end else begin
          nxt = FETCH;
        end
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_RTYPE:      nxt = RTYPEEX;
          OP_LW, OP_SW:  nxt = MEMADR;
          OP_BEQ, OP_BNE: nxt = BRANCH;
          OP_ADDI:       nxt = ADDIEX;
          OP_J:          nxt = JUMP;
          default: begin
            illegalOp = 1'b1;
            nxt       = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        nxt     = memReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        retire   = memReady;
        nxt      = memReady ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        if (jrEnable) begin
          PCWrite  = 1'b1;
          PCSource = 2'b11;
          retire   = 1'b1;
        end else begin
          nxt = RTYPEWB;
        end
      end
      RTYPEWB: begin
        ALUOp    = 2'b10;
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        branchNe    = (opcode == OP_BNE);
        retire      = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
      end
      default: nxt = FETCH;
    endcase
    // Reset blanks every control line in the same cycle, even mid-instruction.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      branchNe    = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      illegalOp   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur        <= FETCH;
      instrCount <= '0;
    end else begin
      cur <= nxt;
      if (retire) begin
        instrCount <= instrCount + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       jrEnable;
  logic       memReady;
  logic       PCWrite, PCWriteCond, branchNe, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegalOp;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic [3:0] instrCount;

  multicycle_control #(.COUNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .jrEnable(jrEnable),
    .memReady(memReady), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .branchNe(branchNe), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .illegalOp(illegalOp), .state(state), .instrCount(instrCount)
  );

  always #5 clk = ~clk;

  // Flattened control word, bit 17 = PCWrite down to bit 0 = illegalOp.
  logic [17:0] outs;
  assign outs = {PCWrite, PCWriteCond, branchNe, IorD, MemRead, MemWrite, IRWrite,
                 MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegalOp};

  localparam logic [17:0] PCW = 18'h20000, PCWC = 18'h10000, BNE = 18'h08000;
  localparam logic [17:0] IORD = 18'h04000, MRD = 18'h02000, MWR = 18'h01000;
  localparam logic [17:0] IRW = 18'h00800, M2R = 18'h00400, RDST = 18'h00200;
  localparam logic [17:0] RW = 18'h00100, ASA = 18'h00080, ILL = 18'h00001;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNEOP = 6'b000101, ADDI = 6'b001000, JOP = 6'b000010;

  function automatic logic [17:0] srcb(input int v); return 18'(v) << 5; endfunction
  function automatic logic [17:0] aop(input int v);  return 18'(v) << 3; endfunction
  function automatic logic [17:0] pcs(input int v);  return 18'(v) << 1; endfunction

  typedef struct {
    logic [3:0]  st;
    logic [17:0] o;
    logic        mr;
  } cyc_t;

  typedef struct {
    logic [5:0] op;
    logic       jr;
    int         lat;
    int         inc;
  } vec_t;

  int compared = 0;
  int mismatched = 0;
  logic [3:0] exp_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op inside {RT, LW, SW, BEQ, BNEOP, ADDI, JOP};
  endfunction

  // Expands one instruction into its expected per-cycle trace, then plays it.
  task automatic run_instr(input logic [5:0] op, input logic jr, input int fs, input int ms);
    cyc_t q[$];
    bit   ret;
    q.push_back('{4'd0, MRD | srcb(1), 1'b0});
    for (int i = 0; i < fs; i++) q.push_back('{4'd0, MRD | srcb(1), 1'b0});
    q.delete(0);
    q.push_back('{4'd0, MRD | srcb(1) | IRW | PCW, 1'b1});
    q.push_back('{4'd1, srcb(3) | (legal(op) ? 18'h0 : ILL), 1'($urandom)});
    ret = legal(op);
    case (op)
      LW: begin
        q.push_back('{4'd2, ASA | srcb(2), 1'($urandom)});
        for (int i = 0; i < ms; i++) q.push_back('{4'd3, MRD | IORD, 1'b0});
        q.push_back('{4'd3, MRD | IORD, 1'b1});
        q.push_back('{4'd4, RW | M2R, 1'($urandom)});
      end
      SW: begin
        q.push_back('{4'd2, ASA | srcb(2), 1'($urandom)});
        for (int i = 0; i < ms; i++) q.push_back('{4'd5, MWR | IORD, 1'b0});
        q.push_back('{4'd5, MWR | IORD, 1'b1});
      end
      RT: begin
        q.push_back('{4'd6, ASA | aop(2) | (jr ? (PCW | pcs(3)) : 18'h0), 1'($urandom)});
        if (!jr) q.push_back('{4'd7, aop(2) | RW | RDST, 1'($urandom)});
      end
      BEQ, BNEOP: q.push_back('{4'd8, ASA | aop(1) | PCWC | pcs(1) | (op == BNEOP ? BNE : 18'h0), 1'($urandom)});
      ADDI: begin
        q.push_back('{4'd9, ASA | srcb(2), 1'($urandom)});
        q.push_back('{4'd10, RW, 1'($urandom)});
      end
      JOP: q.push_back('{4'd11, PCW | pcs(2), 1'($urandom)});
      default: ;
    endcase
    foreach (q[i]) begin
      opcode   = op;
      jrEnable = (op == RT) ? jr : 1'($urandom);
      memReady = q[i].mr;
      @(negedge clk);
      check($sformatf("trace op=%b cyc%0d", op, i), {14'h0, q[i].st, outs}, {14'h0, q[i].st, q[i].o});
      @(posedge clk); #1;
    end
    if (ret) exp_count = exp_count + 4'd1;
    check("count after instr", 32'(instrCount), 32'(exp_count));
    check("back in fetch", 32'(state), 32'd0);
  endtask

  vec_t tbl[9];
  logic [5:0] rop;
  int n;
  logic [3:0] c0;

  initial begin
    reset = 1'b1; opcode = LW; jrEnable = 1'b0; memReady = 1'b1;
    @(posedge clk); #1;
    check("outputs zero in reset", 32'(outs), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset state", 32'(state), 32'd0);
    check("reset count", 32'(instrCount), 32'd0);
    exp_count = 4'd0;

    // Latency table with memReady held high.
    tbl[0] = '{LW, 1'b0, 5, 1};    tbl[1] = '{SW, 1'b0, 4, 1};
    tbl[2] = '{RT, 1'b0, 4, 1};    tbl[3] = '{RT, 1'b1, 3, 1};
    tbl[4] = '{BEQ, 1'b0, 3, 1};   tbl[5] = '{BNEOP, 1'b0, 3, 1};
    tbl[6] = '{ADDI, 1'b0, 4, 1};  tbl[7] = '{JOP, 1'b0, 3, 1};
    tbl[8] = '{6'b111111, 1'b0, 2, 0};
    foreach (tbl[k]) begin
      opcode = tbl[k].op; jrEnable = tbl[k].jr; memReady = 1'b1;
      c0 = instrCount;
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (state != 4'd0 && n < 20);
      check($sformatf("latency op=%b jr=%0d", tbl[k].op, tbl[k].jr), 32'(n), 32'(tbl[k].lat));
      check($sformatf("retire op=%b", tbl[k].op), 32'(4'(instrCount - c0)), 32'(tbl[k].inc));
      exp_count = exp_count + 4'(tbl[k].inc);
    end

    // Directed corner cases through the trace model.
    run_instr(LW, 1'b0, 0, 0);
    run_instr(SW, 1'b0, 1, 3);
    run_instr(RT, 1'b1, 0, 0);
    run_instr(BNEOP, 1'b0, 2, 0);
    run_instr(6'b111111, 1'b0, 0, 0);

    // Randomized instruction stream.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 8))
        0: rop = LW;  1: rop = SW;  2: rop = RT;  3: rop = BEQ;  4: rop = BNEOP;
        5: rop = ADDI; 6: rop = JOP; 7: rop = RT;
        default: rop = 6'($urandom);
      endcase
      run_instr(rop, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset asserted while waiting in MEMRD.
    opcode = LW; memReady = 1'b1; jrEnable = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    memReady = 1'b0;
    #1;
    check("in memrd before reset", 32'(state), 32'd3);
    reset = 1'b1;
    #1;
    check("outputs zero mid-instr reset", 32'(outs), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("state after mid reset", 32'(state), 32'd0);
    check("count after mid reset", 32'(instrCount), 32'd0);
    exp_count = 4'd0;

    // Counter wrap: 15 jumps then one more.
    for (int i = 0; i < 15; i++) run_instr(JOP, 1'b0, 0, 0);
    check("count at 15", 32'(instrCount), 32'd15);
    run_instr(JOP, 1'b0, 0, 0);
    check("count wrapped", 32'(instrCount), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
